// File: rtl/hdr_exit_restart_detector.sv
// HDR-DDR Exit / Restart pattern detector: synchronizes raw SCL/SDA, counts SDA
// falls while SCL is low, and raises one-cycle pulses for the Exit and Restart patterns.
module hdr_exit_restart_detector #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic       i_en,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_exitdet_EXIT,
  output logic       o_rstdet_RESTART,
  output logic [2:0] o_fall_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_EXIT_HOLD = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_p;
  logic                   r_sda_p;
  logic                   r_scl_rise;
  logic                   r_sda_fall;
  logic                   w_scl_s;
  logic                   w_sda_s;

  state_t                 r_state;
  logic [2:0]             r_cnt;
  logic                   r_exit;
  logic                   r_restart;

  assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s = r_sda_sync[SYNC_STAGES-1];

  // NOTE: pin flops reset to 1 (idle bus) so releasing reset on a quiet bus
  // never looks like a falling edge.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_p    <= 1'b1;
      r_sda_p    <= 1'b1;
      r_scl_rise <= 1'b0;
      r_sda_fall <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop here sample the value
      // from before this edge, which is what builds the shift chain.
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_p    <= w_scl_s;
      r_sda_p    <= w_sda_s;
      r_scl_rise <= w_scl_s & ~r_scl_p;
      r_sda_fall <= ~w_sda_s & r_sda_p & ~w_scl_s;
    end
  end

  // The edge flags are registered, so r_scl_p / r_sda_p are the pin levels
  // belonging to the same sample as r_scl_rise / r_sda_fall.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 3'd0;
      r_exit    <= 1'b0;
      r_restart <= 1'b0;
    end else begin
      r_exit    <= 1'b0;
      r_restart <= 1'b0;
      if (!i_en) begin
        r_state <= ST_IDLE;
        r_cnt   <= 3'd0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            r_cnt <= 3'd0;
            if (!r_scl_p) begin
              r_state <= ST_ARMED;
              if (r_sda_fall) r_cnt <= 3'd1;
            end
          end
          ST_ARMED: begin
            // SCL rise wins over a same-sample SDA fall; that fall is dropped.
            if (r_scl_rise) begin
              r_state <= ST_IDLE;
              r_cnt   <= 3'd0;
              if (r_cnt == 3'd2 && r_sda_p) r_restart <= 1'b1;
            end else if (r_sda_fall) begin
              r_cnt <= r_cnt + 3'd1;
              if (r_cnt == 3'd3) begin
                r_exit  <= 1'b1;
                r_state <= ST_EXIT_HOLD;
              end
            end
          end
          ST_EXIT_HOLD: begin
            if (r_scl_rise) begin
              r_state <= ST_IDLE;
              r_cnt   <= 3'd0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
          end
        endcase
      end
    end
  end

  assign o_exitdet_EXIT   = r_exit;
  assign o_rstdet_RESTART = r_restart;
  assign o_fall_cnt       = r_cnt;

endmodule

// File: tb/tb_hdr_exit_restart_detector.sv
// Scoreboard bench for hdr_exit_restart_detector: two instances (2 and 3
// synchronizer stages) watch the same pins; expected pulses are queued per instance.
module tb_hdr_exit_restart_detector;

  localparam logic [1:0] K_EXIT    = 2'b10;
  localparam logic [1:0] K_RESTART = 2'b01;

  typedef struct {
    int         cyc;
    logic [1:0] kind;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       scl;
  logic       sda;
  logic       exit2, restart2, exit3, restart3;
  logic [2:0] cnt2, cnt3;

  int   cyc;
  int   checks;
  int   errors;
  exp_t q2[$];
  exp_t q3[$];

  hdr_exit_restart_detector #(.SYNC_STAGES(2)) u_dut2 (
    .i_sys_clk        (clk),
    .i_sys_rst        (rst_n),
    .i_en             (en),
    .i_scl            (scl),
    .i_sda            (sda),
    .o_exitdet_EXIT   (exit2),
    .o_rstdet_RESTART (restart2),
    .o_fall_cnt       (cnt2)
  );

  hdr_exit_restart_detector #(.SYNC_STAGES(3)) u_dut3 (
    .i_sys_clk        (clk),
    .i_sys_rst        (rst_n),
    .i_en             (en),
    .i_scl            (scl),
    .i_sda            (sda),
    .o_exitdet_EXIT   (exit3),
    .o_rstdet_RESTART (restart3),
    .o_fall_cnt       (cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got cyc=%0d required completion", cyc);
    $fatal(1);
  end

  // Pulse monitor for the 2-stage instance
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (exit2 && restart2) begin
      errors++;
      $display("FAIL excl2: both pulses high at cyc %0d, required at most one", cyc);
    end
    if (q2.size() > 0 && q2[0].cyc < cyc) begin
      e = q2.pop_front();
      checks++; errors++;
      $display("FAIL missed2: no pulse seen, required kind %b at cyc %0d", e.kind, e.cyc);
    end
    if (exit2 || restart2) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL unexpected2: pulse %b at cyc %0d, required none", {exit2, restart2}, cyc);
      end else begin
        e = q2.pop_front();
        if (e.cyc !== cyc || e.kind !== {exit2, restart2}) begin
          errors++;
          $display("FAIL pulse2: got kind %b at cyc %0d, required kind %b at cyc %0d",
                   {exit2, restart2}, cyc, e.kind, e.cyc);
        end
      end
    end
  end

  // Pulse monitor for the 3-stage instance
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (exit3 && restart3) begin
      errors++;
      $display("FAIL excl3: both pulses high at cyc %0d, required at most one", cyc);
    end
    if (q3.size() > 0 && q3[0].cyc < cyc) begin
      e = q3.pop_front();
      checks++; errors++;
      $display("FAIL missed3: no pulse seen, required kind %b at cyc %0d", e.kind, e.cyc);
    end
    if (exit3 || restart3) begin
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL unexpected3: pulse %b at cyc %0d, required none", {exit3, restart3}, cyc);
      end else begin
        e = q3.pop_front();
        if (e.cyc !== cyc || e.kind !== {exit3, restart3}) begin
          errors++;
          $display("FAIL pulse3: got kind %b at cyc %0d, required kind %b at cyc %0d",
                   {exit3, restart3}, cyc, e.kind, e.cyc);
        end
      end
    end
  end

  // Wait n rising edges, then settle 2 ns; all driving and level checks happen here.
  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // A pin change driven now is first sampled on the next edge (cyc+1);
  // the pulse lands SYNC_STAGES+1 edges after that.
  task automatic expect_pulse(input logic [1:0] kind);
    q2.push_back('{cyc: cyc + 4, kind: kind});
    q3.push_back('{cyc: cyc + 5, kind: kind});
  endtask

  task automatic chk_cnt(input logic [2:0] exp, input string name);
    checks += 2;
    if (cnt2 !== exp) begin
      errors++;
      $display("FAIL %s (ss2): fall_cnt=%0d required %0d", name, cnt2, exp);
    end
    if (cnt3 !== exp) begin
      errors++;
      $display("FAIL %s (ss3): fall_cnt=%0d required %0d", name, cnt3, exp);
    end
  endtask

  // SCL low, SDA 1->0->1->0->1, SCL rise. Pulses and counts only when enabled.
  task automatic run_restart(input bit on, input string name);
    scl = 1'b0; hold(8); chk_cnt(3'd0, {name, "_armed"});
    sda = 1'b0; hold(8); chk_cnt(on ? 3'd1 : 3'd0, {name, "_f1"});
    sda = 1'b1; hold(8);
    sda = 1'b0; hold(8); chk_cnt(on ? 3'd2 : 3'd0, {name, "_f2"});
    sda = 1'b1; hold(8); chk_cnt(on ? 3'd2 : 3'd0, {name, "_f2_hi"});
    scl = 1'b1;
    if (on) expect_pulse(K_RESTART);
    hold(10); chk_cnt(3'd0, {name, "_done"});
  endtask

  // SCL low, four SDA falls, SCL rise with SDA low, then SDA rise (STOP).
  task automatic run_exit(input bit on, input string name);
    scl = 1'b0; hold(8);
    for (int i = 0; i < 4; i++) begin
      sda = 1'b0;
      if (on && i == 3) expect_pulse(K_EXIT);
      hold(8);
      chk_cnt(on ? 3'(i + 1) : 3'd0, $sformatf("%s_f%0d", name, i + 1));
      if (i < 3) begin
        sda = 1'b1; hold(8);
      end
    end
    scl = 1'b1; hold(10); chk_cnt(3'd0, {name, "_scl_rise"});
    sda = 1'b1; hold(8);  chk_cnt(3'd0, {name, "_stop"});
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; scl = 1'b1; sda = 1'b1;
    hold(3);
    checks += 2;
    if ({exit2, restart2, exit3, restart3} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pulses: got %b required 0000", {exit2, restart2, exit3, restart3});
    end
    if (u_dut2.w_scl_s !== 1'b1 || u_dut2.w_sda_s !== 1'b1) begin
      errors++;
      $display("FAIL reset_sync: scl_s=%b sda_s=%b required 1 1", u_dut2.w_scl_s, u_dut2.w_sda_s);
    end
    chk_cnt(3'd0, "reset_cnt");
    rst_n = 1'b1;
    hold(4);
  endtask

  task automatic test_restart();
    en = 1'b1; hold(8);
    run_restart(1'b1, "restart");
  endtask

  task automatic test_exit();
    run_exit(1'b1, "exit");
  endtask

  task automatic test_data();
    for (int i = 0; i < 3; i++) begin
      sda = 1'b0; hold(4);
      sda = 1'b1; hold(4);
    end
    chk_cnt(3'd0, "data_scl_high");
    scl = 1'b0; hold(8);
    sda = 1'b0; hold(8); chk_cnt(3'd1, "data_one_fall");
    scl = 1'b1; hold(8); chk_cnt(3'd0, "data_one_rise");
    sda = 1'b1; hold(8);
    scl = 1'b0; hold(8);
    for (int i = 0; i < 3; i++) begin
      sda = 1'b0; hold(8);
      if (i < 2) begin
        sda = 1'b1; hold(8);
      end
    end
    chk_cnt(3'd3, "data_three_falls");
    scl = 1'b1; hold(8); chk_cnt(3'd0, "data_three_rise");
    sda = 1'b1; hold(8);
  endtask

  task automatic test_disabled();
    en = 1'b0; hold(4);
    run_exit(1'b0, "dis_exit");
    run_restart(1'b0, "dis_restart");
    en = 1'b1; hold(8);
  endtask

  task automatic test_midpattern(input bit use_reset, input string name);
    scl = 1'b0; hold(8);
    sda = 1'b0; hold(8);
    sda = 1'b1; hold(8);
    sda = 1'b0; hold(8);
    sda = 1'b1; hold(8);
    chk_cnt(3'd2, {name, "_before"});
    if (use_reset) rst_n = 1'b0; else en = 1'b0;
    hold(2);
    chk_cnt(3'd0, {name, "_during"});
    rst_n = 1'b1; en = 1'b1;
    hold(8);
    chk_cnt(3'd0, {name, "_after"});
    scl = 1'b1; hold(10);
    chk_cnt(3'd0, {name, "_scl_rise"});
  endtask

  task automatic test_simultaneous();
    scl = 1'b0; hold(8);
    sda = 1'b0; hold(8);
    sda = 1'b1; hold(8);
    sda = 1'b0; hold(8);
    sda = 1'b1; hold(8);
    chk_cnt(3'd2, "simul_before");
    scl = 1'b1; sda = 1'b0;
    for (int i = 0; i < 10; i++) begin
      hold(1);
      checks++;
      if (cnt2 !== 3'd2 && cnt2 !== 3'd0) begin
        errors++;
        $display("FAIL simul_no_incr: fall_cnt=%0d required 2 or 0", cnt2);
      end
    end
    chk_cnt(3'd0, "simul_idle");
    sda = 1'b1; hold(8);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    @(posedge clk); #2;
    test_reset();
    test_restart();
    test_exit();
    test_data();
    test_disabled();
    test_midpattern(1'b1, "mid_reset");
    test_midpattern(1'b0, "mid_en");
    test_simultaneous();
    test_restart();
    hold(20);
    checks += 2;
    if (q2.size() != 0) begin
      errors++;
      $display("FAIL pending2: %0d pulses outstanding, required 0", q2.size());
    end
    if (q3.size() != 0) begin
      errors++;
      $display("FAIL pending3: %0d pulses outstanding, required 0", q3.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdr_exit_restart_detector.md
Name: hdr_exit_restart_detector

Overview:
- Monitors the I3C bus pins while the target is in HDR-DDR mode and detects the HDR Restart and HDR Exit patterns.
- Its single-cycle pulses feed the target engine's exit-detect and restart-detect inputs. Exit returns the engine to SDR idle; Restart re-enters initialization.
- Pins are asynchronous to i_sys_clk. They are synchronized internally, and all pattern decoding runs on synchronized samples.

Parameters:
SYNC_STAGES, 2, number of flip-flops in each pin synchronizer (legal values 2 and 3)

Ports:
i_sys_clk  input  1  system clock
i_sys_rst  input  1  asynchronous, active-low reset
i_en  input  1  detection enable; high while the engine is in any HDR state
i_scl  input  1  raw SCL pin, asynchronous
i_sda  input  1  raw SDA pin, asynchronous
o_exitdet_EXIT  output  1  one-cycle pulse: HDR Exit pattern detected
o_rstdet_RESTART  output  1  one-cycle pulse: HDR Restart pattern detected
o_fall_cnt  output  3  current count of SDA falling edges while SCL is low (debug)

Behaviour:
- Reset (i_sys_rst=0, asynchronous):
  - All synchronizer and previous-sample flops reset to 1 (idle bus).
  - State=IDLE, count=0, o_exitdet_EXIT=0, o_rstdet_RESTART=0, o_fall_cnt=0.
- Synchronization and edge detection:
  - scl_s and sda_s are the last synchronizer stage. scl_p and sda_p are the same signals delayed one cycle.
  - scl_rise = scl_s & ~scl_p.
  - sda_fall = ~sda_s & sda_p & ~scl_s (SDA falling while SCL is low).
- Outputs are registered. A pulse is high for exactly one cycle, SYNC_STAGES+1 rising edges after the clock edge that first samples the qualifying pin change.
- FSM:
  - IDLE:
    - count=0.
    - When i_en=1 and scl_s=0, go to ARMED.
    - If the qualifying sda_fall is present in that same cycle, count it (count becomes 1).
  - ARMED:
    - On sda_fall: count=count+1.
    - If the new count equals 4: pulse o_exitdet_EXIT and go to EXIT_HOLD.
    - On scl_rise with count==2 and sda_s==1: pulse o_rstdet_RESTART, count=0, go to IDLE.
    - On scl_rise under any other condition: count=0, go to IDLE, no pulse. This is ordinary DDR data or command activity.
  - EXIT_HOLD:
    - No further pulses; SDA edges are ignored.
    - On scl_rise (the STOP), or when i_en=0: count=0, go to IDLE.
- Simultaneous events:
  - scl_rise takes priority over sda_fall in the same cycle.
  - The count used for the Restart check is the count before that cycle's fall, and the fall is discarded.
  - Because SDA is low in that case, no Restart is flagged.
- i_en=0:
  - From any state, next state is IDLE and count=0 on the following edge. No pulse is issued in that cycle.
  - Synchronizers keep running, so stale edges are not seen when enable returns.
- Count width is 3 bits and is never incremented past 4.
- o_exitdet_EXIT and o_rstdet_RESTART are never high in the same cycle.
- o_fall_cnt mirrors the count register.
- Reset mid-pattern abandons the pattern. The next pattern must start from IDLE.
- Implementation: a single 3-state FSM with registered next-state, count and pulse logic, plus per-pin synchronizers.

Test Plan:
1. Restart:
   - Stimulus: i_en=1; SCL low; SDA 1->0->1->0->1, each level held 8 clk; then SCL rises.
   - Response: o_rstdet_RESTART high exactly 1 cycle, 3 clk after the SCL-rise sample (SYNC_STAGES=2). o_exitdet_EXIT stays 0. o_fall_cnt goes 0,1,2,0.
2. Exit:
   - Stimulus: i_en=1; SCL low; 4 SDA falling edges; then SCL rises with SDA low, then SDA rises (STOP).
   - Response: o_exitdet_EXIT pulses once, 3 clk after the 4th falling sample. No Restart pulse on the later SCL rise. State returns to IDLE with o_fall_cnt=0.
3. Data traffic:
   - Stimulus: SDA toggles while SCL is high (no effect); then SCL low, 1 SDA fall, SCL rise. Then SCL low, 3 SDA falls, SCL rise.
   - Response: no pulses in either case; o_fall_cnt returns to 0 after each SCL rise.
4. Disabled:
   - Stimulus: i_en=0; drive the full Exit pattern, then the full Restart pattern.
   - Response: both outputs stay 0 and o_fall_cnt stays 0.
5. Mid-pattern disturbances:
   - Stimulus A: after 2 SDA falls, assert i_sys_rst low for 2 clk, release, then raise SCL. Response: no Restart pulse; o_fall_cnt=0 right after reset.
   - Stimulus B: repeat, but drop i_en instead of reset. Response: identical.
6. Simultaneous:
   - Stimulus: count=2; SCL rise and SDA fall reach the synchronizers on the same clock edge.
   - Response: no Restart, no count increment, return to IDLE.
   - Repeat with SYNC_STAGES=3: the Restart of scenario 1 now appears at 4 clk latency.
